// File: rtl/ysyx_22050612_ifu_pkg.sv
// rtl/ysyx_22050612_ifu_pkg.sv - shared constants and types for the instruction fetch unit
// Contents: boot PC, NOP encoding, FSM state encoding, queue entry layout, PC alignment helper.
package ysyx_22050612_ifu_pkg;

    localparam logic [63:0] RESET_PC = 64'h8000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    localparam logic [1:0] ST_REQ  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    localparam int ENTRY_W = 96;

    typedef enum logic [1:0] {
        S_REQ  = ST_REQ,
        S_WAIT = ST_WAIT,
        S_DROP = ST_DROP
    } state_e;

    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] pc;
    } entry_t;

    // Clears the byte-offset bits so every fetch address is word aligned.
    function automatic logic [63:0] align_word(input logic [63:0] addr);
        return addr & ~64'd3;
    endfunction

endpackage

// File: rtl/ysyx_22050612_ifu_fifo.sv
// rtl/ysyx_22050612_ifu_fifo.sv - 2-entry queue holding fetched {inst, pc} pairs
// Ports: clk, rst (async, active-high); push/push_data, pop, flush inputs;
//        count, head_valid, head_data outputs (head driven straight from storage).
module ysyx_22050612_ifu_fifo #(
    parameter int WIDTH = 96
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [1:0]       count,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data
);

    logic [WIDTH-1:0] mem_q [2];
    logic [WIDTH-1:0] mem_d [2];
    logic             rd_ptr_q, rd_ptr_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             do_push, do_pop;

    // A push into a full queue is only allowed when a pop frees a slot the same cycle.
    assign do_pop  = pop && (count_q != 2'd0);
    assign do_push = push && ((count_q != 2'd2) || do_pop);

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count      = count_q;
    assign head_valid = (count_q != 2'd0);
    assign head_data  = mem_q[rd_ptr_q];

endmodule

// File: rtl/ysyx_22050612_ifu.sv
// rtl/ysyx_22050612_ifu.sv - instruction fetch stage: PC, one-outstanding imem request FSM, decode queue
// Ports: clk, rst (async, active-high); redirect_valid/redirect_pc from execute;
//        imem_req_valid/ready/addr request channel; imem_rsp_valid/data response channel;
//        out_valid/out_ready/out_inst/out_pc toward decode.
module ysyx_22050612_ifu
    import ysyx_22050612_ifu_pkg::*;
#(
    parameter logic [63:0] BOOT_PC = RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [63:0] out_pc
);

    state_e      state_q, state_d;
    logic [63:0] fetch_pc_q, fetch_pc_d;
    logic [63:0] inflight_pc_q, inflight_pc_d;

    logic [1:0]  fifo_count;
    logic        fifo_push, fifo_pop, fifo_flush;
    logic        head_valid;
    entry_t      head_entry, push_entry;

    logic        req_fire, rsp_take;

    // Requests only leave from REQ, where nothing is outstanding, so a free slot
    // in the queue is enough credit for the reply that will follow.
    assign imem_req_valid = !rst && (state_q == S_REQ) && (fifo_count < 2'd2);
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_take       = imem_rsp_valid && (state_q != S_REQ);
    assign push_entry     = '{inst: imem_rsp_data, pc: inflight_pc_q};

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        fifo_push     = 1'b0;
        fifo_pop      = head_valid && out_ready;
        fifo_flush    = 1'b0;

        case (state_q)
            S_REQ: begin
                if (req_fire) begin
                    inflight_pc_d = fetch_pc_q;
                    fetch_pc_d    = fetch_pc_q + 64'd4;
                    state_d       = S_WAIT;
                end
            end
            S_WAIT: begin
                if (rsp_take) begin
                    fifo_push = 1'b1;
                    state_d   = S_REQ;
                end
            end
            S_DROP: begin
                if (rsp_take) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase

        // Redirect wins over everything: the queue is wiped and whatever request
        // is still outstanding after this edge must have its reply discarded.
        if (redirect_valid) begin
            fetch_pc_d = align_word(redirect_pc);
            fifo_flush = 1'b1;
            fifo_push  = 1'b0;
            fifo_pop   = 1'b0;
            if ((state_q == S_REQ && req_fire) || (state_q != S_REQ && !rsp_take)) begin
                state_d = S_DROP;
            end else begin
                state_d = S_REQ;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_REQ;
            fetch_pc_q    <= BOOT_PC;
            inflight_pc_q <= BOOT_PC;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    ysyx_22050612_ifu_fifo #(
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (fifo_push),
        .push_data  (push_entry),
        .pop        (fifo_pop),
        .flush      (fifo_flush),
        .count      (fifo_count),
        .head_valid (head_valid),
        .head_data  (head_entry)
    );

    assign out_valid = head_valid;
    assign out_inst  = head_entry.inst;
    assign out_pc    = head_entry.pc;

endmodule

// File: tb/tb_ysyx_22050612_ifu.sv
// tb/tb_ysyx_22050612_ifu.sv - self-checking bench for the instruction fetch unit
module tb_ysyx_22050612_ifu;

    localparam logic [63:0] RST_PC = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [63:0] out_pc;

    always #5 clk = ~clk;

    ysyx_22050612_ifu dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Memory model: one outstanding request, reply after m_delay idle cycles.
    bit          m_pend;
    bit          m_drop;
    logic [63:0] m_addr;
    int          m_delay;
    int          delay_lo;
    int          delay_hi;
    bit          stray_rsp;

    // Reference: PCs decode should see, next address to request, and observed pops.
    logic [63:0] exp_q[$];
    logic [63:0] exp_addr;
    logic [63:0] popped[$];

    function automatic logic [31:0] inst_of(input logic [63:0] a);
        return a[31:0] ^ 32'h00c0_ffee;
    endfunction

    task automatic tick();
        logic        rf, sf, pf;
        logic [63:0] ra, opc;
        imem_rsp_valid = (m_pend && m_delay == 0) || stray_rsp;
        imem_rsp_data  = m_pend ? inst_of(m_addr) : 32'hdead_beef;
        #1;
        rf  = imem_req_valid && imem_req_ready;
        sf  = imem_rsp_valid;
        pf  = out_valid && out_ready;
        ra  = imem_req_addr;
        opc = out_pc;
        if (rst) begin
            n_checks++;
            if (imem_req_valid !== 1'b0 || out_valid !== 1'b0 || imem_req_addr !== RST_PC
                || out_inst !== 32'd0 || out_pc !== 64'd0) begin
                n_errors++;
                $display("FAIL reset_state: req_v=%b out_v=%b addr=%h inst=%h pc=%h expected 0 0 %h 0 0",
                         imem_req_valid, out_valid, imem_req_addr, out_inst, out_pc, RST_PC);
            end
        end else begin
            n_checks++;
            if (out_valid !== (exp_q.size() != 0)) begin
                n_errors++;
                $display("FAIL out_valid: got %b expected %b", out_valid, exp_q.size() != 0);
            end
            if (out_valid === 1'b1 && exp_q.size() != 0) begin
                n_checks++;
                if (out_pc !== exp_q[0] || out_inst !== inst_of(exp_q[0])) begin
                    n_errors++;
                    $display("FAIL head: got pc=%h inst=%h expected pc=%h inst=%h",
                             out_pc, out_inst, exp_q[0], inst_of(exp_q[0]));
                end
            end
            n_checks++;
            if (imem_req_valid !== (!m_pend && exp_q.size() < 2)) begin
                n_errors++;
                $display("FAIL req_valid: got %b expected %b", imem_req_valid, !m_pend && exp_q.size() < 2);
            end
            if (imem_req_valid === 1'b1) begin
                n_checks++;
                if (imem_req_addr !== exp_addr) begin
                    n_errors++;
                    $display("FAIL req_addr: got %h expected %h", imem_req_addr, exp_addr);
                end
            end
        end
        @(posedge clk);
        if (rst) begin
            m_pend   = 0;
            m_drop   = 0;
            exp_q.delete();
            exp_addr = RST_PC;
        end else begin
            if (pf) popped.push_back(opc);
            if (redirect_valid) begin
                exp_q.delete();
                if (m_pend && !sf) m_drop = 1;
                exp_addr = redirect_pc & ~64'd3;
            end else begin
                if (pf && exp_q.size() != 0) void'(exp_q.pop_front());
                if (sf && m_pend && !m_drop) exp_q.push_back(m_addr);
            end
            if (sf && m_pend) m_pend = 0;
            else if (m_pend && m_delay > 0) m_delay--;
            if (rf) begin
                m_pend  = 1;
                m_addr  = ra;
                m_drop  = redirect_valid;
                m_delay = $urandom_range(delay_hi, delay_lo);
                if (!redirect_valid) exp_addr = exp_addr + 64'd4;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 64'd0;
        imem_req_ready = 1'b0;
        out_ready      = 1'b0;
        stray_rsp      = 1'b0;
        delay_lo       = 0;
        delay_hi       = 0;
        tick();
        tick();
        rst = 1'b0;
        popped.delete();
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin
            n_errors++;
            $display("FAIL first_req: got v=%b addr=%h expected 1 %h", imem_req_valid, imem_req_addr, RST_PC);
        end
        tick();
    endtask

    task automatic test_in_order();
        do_reset();
        imem_req_ready = 1'b1;
        out_ready      = 1'b1;
        for (int i = 0; i < 40 && popped.size() < 3; i++) tick();
        n_checks++;
        if (popped.size() < 3) begin
            n_errors++;
            $display("FAIL in_order_timeout: got %0d pops expected 3", popped.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (popped[i] !== RST_PC + 64'(4 * i)) begin
                    n_errors++;
                    $display("FAIL in_order_pc%0d: got %h expected %h", i, popped[i], RST_PC + 64'(4 * i));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        bit seen;
        do_reset();
        imem_req_ready = 1'b1;
        out_ready      = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        #1;
        n_checks++;
        if (imem_req_valid !== 1'b0 || out_valid !== 1'b1 || out_pc !== RST_PC) begin
            n_errors++;
            $display("FAIL backpressure_hold: got req_v=%b out_v=%b pc=%h expected 0 1 %h",
                     imem_req_valid, out_valid, out_pc, RST_PC);
        end
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            #1;
            if (imem_req_valid === 1'b1) begin
                seen = 1;
                n_checks++;
                if (imem_req_addr !== RST_PC + 64'd8) begin
                    n_errors++;
                    $display("FAIL resume_addr: got %h expected %h", imem_req_addr, RST_PC + 64'd8);
                end
            end
            tick();
        end
        for (int i = 0; i < 6; i++) tick();
        n_checks++;
        if (!seen || popped.size() < 2 || popped[0] !== RST_PC || popped[1] !== RST_PC + 64'd4) begin
            n_errors++;
            $display("FAIL drain: got seen=%b pops=%0d expected resume and pcs %h %h",
                     seen, popped.size(), RST_PC, RST_PC + 64'd4);
        end
    endtask

    task automatic test_redirect_wait();
        bit seen;
        do_reset();
        imem_req_ready = 1'b1;
        out_ready      = 1'b1;
        delay_lo       = 1;
        delay_hi       = 1;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_1003;
        tick();
        redirect_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            #1;
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL redirect_wait_outv: got %b expected 0", out_valid);
            end
            if (imem_req_valid === 1'b1) begin
                seen = 1;
                n_checks++;
                if (imem_req_addr !== 64'h8000_1000) begin
                    n_errors++;
                    $display("FAIL redirect_wait_addr: got %h expected %h", imem_req_addr, 64'h8000_1000);
                end
            end
            tick();
        end
        for (int i = 0; i < 10 && popped.size() == 0; i++) tick();
        n_checks++;
        if (!seen || popped.size() == 0 || popped[0] !== 64'h8000_1000) begin
            n_errors++;
            $display("FAIL redirect_wait_first: got seen=%b pops=%0d expected first pc %h",
                     seen, popped.size(), 64'h8000_1000);
        end
    endtask

    task automatic test_redirect_rsp();
        bit ok;
        do_reset();
        imem_req_ready = 1'b1;
        out_ready      = 1'b0;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (m_pend && m_delay == 0 && exp_q.size() == 1) ok = 1;
            else tick();
        end
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL redirect_rsp_setup: got %b expected 1", ok);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_2008;
        tick();
        redirect_valid = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_2008) begin
            n_errors++;
            $display("FAIL redirect_rsp_after: got out_v=%b req_v=%b addr=%h expected 0 1 %h",
                     out_valid, imem_req_valid, imem_req_addr, 64'h8000_2008);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        n_checks++;
        if (popped.size() == 0 || popped[0] !== 64'h8000_2008) begin
            n_errors++;
            $display("FAIL redirect_rsp_stream: got pops=%0d expected first pc %h", popped.size(), 64'h8000_2008);
        end
    endtask

    task automatic test_req_stall();
        do_reset();
        imem_req_ready = 1'b0;
        out_ready      = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin
                n_errors++;
                $display("FAIL stall_hold%0d: got v=%b addr=%h expected 1 %h", i, imem_req_valid, imem_req_addr, RST_PC);
            end
            tick();
        end
        imem_req_ready = 1'b1;
        for (int i = 0; i < 10 && popped.size() < 2; i++) tick();
        n_checks++;
        if (popped.size() < 2 || popped[0] !== RST_PC || popped[1] !== RST_PC + 64'd4) begin
            n_errors++;
            $display("FAIL stall_resume: got pops=%0d expected pcs %h %h", popped.size(), RST_PC, RST_PC + 64'd4);
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        imem_req_ready = 1'b1;
        out_ready      = 1'b1;
        delay_lo       = 3;
        delay_hi       = 3;
        tick();
        rst = 1'b1;
        tick();
        rst            = 1'b0;
        imem_req_ready = 1'b0;
        stray_rsp      = 1'b1;
        tick();
        stray_rsp = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin
            n_errors++;
            $display("FAIL stray_rsp: got out_v=%b req_v=%b addr=%h expected 0 1 %h",
                     out_valid, imem_req_valid, imem_req_addr, RST_PC);
        end
        imem_req_ready = 1'b1;
        delay_lo       = 0;
        delay_hi       = 0;
        popped.delete();
        for (int i = 0; i < 10 && popped.size() == 0; i++) tick();
        n_checks++;
        if (popped.size() == 0 || popped[0] !== RST_PC) begin
            n_errors++;
            $display("FAIL reset_restart: got pops=%0d expected first pc %h", popped.size(), RST_PC);
        end
    endtask

    task automatic test_random();
        do_reset();
        delay_lo = 0;
        delay_hi = 3;
        for (int i = 0; i < 3000; i++) begin
            imem_req_ready = ($urandom_range(9) < 7);
            out_ready      = ($urandom_range(9) < 6);
            redirect_valid = ($urandom_range(19) == 0);
            if ($urandom_range(3) == 0)
                redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15));
            else
                redirect_pc = {32'd0, 32'h8000_0000 | $urandom_range(32'hFFFF)};
            tick();
        end
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        out_ready      = 1'b1;
        for (int i = 0; i < 20; i++) tick();
    endtask

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 64'd0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        out_ready      = 1'b0;
        stray_rsp      = 1'b0;
        m_pend         = 0;
        m_drop         = 0;
        m_addr         = 64'd0;
        m_delay        = 0;
        delay_lo       = 0;
        delay_hi       = 0;
        exp_addr       = RST_PC;
        @(negedge clk);
        test_reset();
        test_in_order();
        test_backpressure();
        test_redirect_wait();
        test_redirect_rsp();
        test_req_stall();
        test_reset_midflight();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ysyx_22050612_ifu.md
# ysyx_22050612_ifu

Instruction fetch stage feeding the decode unit. Holds the fetch PC, issues one-at-a-time word requests to instruction memory over a valid/ready request and valid-only response channel, and buffers returned {inst, pc} pairs in a 2-entry queue presented to decode with valid/ready. A redirect from execute (jump/branch) reloads the fetch PC, flushes the queue and discards any in-flight response.

## Interface
- RESET_PC, 64'h8000_0000, first fetch address after reset
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- redirect_valid  in  1  load new fetch PC this cycle
- redirect_pc  in  64  redirect target; bits [1:0] ignored, forced to 0
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  64  fetch address (word aligned)
- imem_rsp_valid  in  1  response data valid (one-cycle pulse per accepted request)
- imem_rsp_data  in  32  fetched instruction word
- out_valid  out  1  queue head valid toward decode
- out_ready  in  1  decode consumes head
- out_inst  out  32  head instruction
- out_pc  out  64  PC of head instruction

## Operation
- Registers: fetch_pc (next address to request), inflight_pc (address of outstanding request), 2-entry FIFO of {inst[31:0], pc[63:0]}, count, state.
- States: REQ, WAIT, DROP. Reset state REQ.
- REQ: imem_req_valid = (count + 0) < 2 (no outstanding request exists in REQ). On req handshake: inflight_pc <= fetch_pc, fetch_pc <= fetch_pc + 4 (64-bit wrap), -> WAIT.
- WAIT: imem_req_valid = 0. On imem_rsp_valid: push {imem_rsp_data, inflight_pc}, -> REQ.
- DROP: imem_req_valid = 0. On imem_rsp_valid: discard data, -> REQ.
- imem_rsp_valid outside WAIT/DROP is ignored.
- Credit rule: request issued only if FIFO has a free slot counting the outstanding one, so a push never hits a full FIFO.
- Pop: out_valid && out_ready; push and pop in same cycle keep count unchanged.
- Redirect (highest priority): fetch_pc <= {redirect_pc[63:2], 2'b00}; FIFO flushed (count <= 0), same-cycle push/pop ignored. Next state: DROP if a request is outstanding after this edge (state WAIT without rsp this cycle, or REQ with req handshake this cycle), else REQ. Redirect in WAIT with rsp same cycle -> REQ, response discarded. Redirect in DROP: reload PC, stay DROP unless rsp same cycle (-> REQ).
- Request accepted in the redirect cycle uses the old fetch_pc; it is dropped.

## Timing
- Reset (async assert): state REQ, fetch_pc = RESET_PC, count 0, out_valid 0, imem_req_valid 0 while rst high, imem_req_addr = RESET_PC, out_inst/out_pc 0.
- First cycle after rst deasserts: imem_req_valid = 1, addr = RESET_PC.
- Request accepted at edge T; response earliest in cycle T+1; entry visible (out_valid = 1) the cycle after response edge. Zero-wait memory: steady throughput 1 instruction per 2 cycles.
- out_inst/out_pc stable while out_valid && !out_ready; outputs driven combinationally from FIFO head registers.
- Cycle after redirect: out_valid = 0; imem_req_addr = new PC if state REQ.
- rst asserted mid-transaction: all state cleared immediately; a later stray response is ignored (state REQ).

## Structure
- Shared header/package: RESET_PC default, 32'h0000_0013 NOP constant, state encoding localparams (REQ=2'd0, WAIT=2'd1, DROP=2'd2).
- One sub-module: ysyx_22050612_ifu_fifo, 2-entry queue, width 96, with push, pop, flush, count, head outputs, async active-high reset.
- Top holds FSM, PC registers, credit logic.

## Test plan
- Reset, memory always ready, rsp one cycle after each req with data = addr[31:0] -> decode sees pc 0x80000000, 0x80000004, 0x80000008 with matching inst, in order.
- out_ready held 0 -> after 2 entries buffered imem_req_valid stays 0; release -> both entries drain, fetch resumes at 0x80000008.
- Redirect to 0x80001003 while in WAIT, rsp arrives next cycle -> response discarded, next request addr 0x80001000, out_valid 0 until its response.
- Redirect same cycle as rsp in WAIT, FIFO holding 1 entry -> FIFO empty next cycle, next request addr = target, no entry with old pc ever emitted.
- imem_req_ready low 5 cycles -> imem_req_valid and addr held stable, fetch_pc not advanced.
- Assert rst with request outstanding, release, send stray rsp -> ignored; first request addr 0x80000000, out_valid 0.
